// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the two-port to line-memory arbiter.
// Provides the arbiter state encoding, line geometry constants, line address
// extraction and the byte-enable word merge used by the read-modify-write path.
package mem_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_A,
      RD_B,
      RMW_RD,
      RMW_WR,
      DONE
   } arb_state_t;

   localparam int unsigned LINE_BYTES = 32;
   localparam int unsigned OFFSET_W   = 5;

   // Line-aligned address: clear the byte offset within the 32-byte line.
   function automatic logic [31:0] line_addr(input logic [31:0] addr);
      return {addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
   endfunction

   // Replace the enabled bytes of word 'off' in 'line' with bytes of 'wdata'.
   function automatic logic [255:0] merge_word(input logic [255:0] line,
                                               input logic [2:0]   off,
                                               input logic [31:0]  wdata,
                                               input logic [3:0]   mbe);
      logic [255:0] r;
      int unsigned  base;
      r    = line;
      base = 32'(off) * 32;
      for (int unsigned i = 0; i < 4; i++) begin
         if (mbe[i]) r[base + 8*i +: 8] = wdata[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_line_merge.sv
// line_merge: combinational word select and byte-enable merge on one 256-bit line.
// The same instance serves the read-data extract and the read-modify-write merge.
module line_merge
   import mem_arb_pkg::*;
(
   input  logic [255:0] line,
   input  logic [2:0]   off,
   input  logic [31:0]  wdata,
   input  logic [3:0]   mbe,
   output logic [31:0]  word,
   output logic [255:0] merged
);

   // Select the addressed word and build the merged line in parallel.
   always_comb begin
      word   = line[{off, 5'b00000} +: 32];
      merged = merge_word(line, off, wdata, mbe);
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises an instruction read port (a) and a data
// read/write port (b) onto one 256-bit line memory. Partial writes are done
// as read-modify-write; responses are single-cycle pulses from DONE.
// Optional: define MEM_PORT_ARBITER_LINE_BUF_EN for a one-entry port-a line buffer.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned LINE_W = 256,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              read_a,
   input  logic [ADDR_W-1:0] address_a,
   output logic              resp_a,
   output logic [31:0]       rdata_a,
   input  logic              read_b,
   input  logic              write,
   input  logic [ADDR_W-1:0] address_b,
   input  logic [31:0]       wdata,
   input  logic [3:0]        mbe,
   output logic              resp_b,
   output logic [31:0]       rdata_b,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   arb_state_t        state, next_state;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [3:0]        mbe_q;
   logic [LINE_W-1:0] line_q;
   logic              port_b_q;

   logic              buf_hit;
   logic [LINE_W-1:0] lm_line;
   logic [2:0]        lm_off;
   logic [31:0]       sel_word;
   logic [LINE_W-1:0] merged_line;

   logic              unused_bits;
   assign unused_bits = ^addr_q[1:0];

   line_merge u_merge (
      .line   (lm_line),
      .off    (lm_off),
      .wdata  (wdata_q),
      .mbe    (mbe_q),
      .word   (sel_word),
      .merged (merged_line)
   );

`ifdef MEM_PORT_ARBITER_LINE_BUF_EN
   logic                       buf_valid;
   logic [ADDR_W-OFFSET_W-1:0] buf_tag;
   logic [LINE_W-1:0]          buf_line;

   // In IDLE the merge unit looks at the buffer so a hit can return its word directly.
   assign buf_hit = buf_valid && (buf_tag == address_a[ADDR_W-1:OFFSET_W]) &&
                    read_a && !read_b && !write;
   assign lm_line = (state == IDLE) ? buf_line : pmem_rdata;
   assign lm_off  = (state == IDLE) ? address_a[4:2] : addr_q[4:2];

   // Buffer fill on every port-a line read; write-back keeps a buffered line coherent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_valid <= 1'b0;
         buf_tag   <= '0;
         buf_line  <= '0;
      end else if (state == RD_A && pmem_resp) begin
         buf_valid <= 1'b1;
         buf_tag   <= addr_q[ADDR_W-1:OFFSET_W];
         buf_line  <= pmem_rdata;
      end else if (state == RMW_WR && pmem_resp && buf_valid &&
                   buf_tag == addr_q[ADDR_W-1:OFFSET_W]) begin
         buf_line  <= line_q;
      end
   end
`else
   assign buf_hit = 1'b0;
   assign lm_line = pmem_rdata;
   assign lm_off  = addr_q[4:2];
`endif

   assign pmem_address = line_addr(addr_q);
   assign pmem_wdata   = line_q;

   // State register; reset abandons any memory transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state and port/memory handshake outputs.
   always_comb begin
      next_state = state;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      resp_a     = 1'b0;
      resp_b     = 1'b0;
      unique case (state)
         IDLE: begin
            if (write)        next_state = RMW_RD;
            else if (read_b)  next_state = RD_B;
            else if (buf_hit) next_state = DONE;
            else if (read_a)  next_state = RD_A;
         end
         RD_A, RD_B: begin
            pmem_read = 1'b1;
            if (pmem_resp) next_state = DONE;
         end
         RMW_RD: begin
            pmem_read = 1'b1;
            if (pmem_resp) next_state = RMW_WR;
         end
         RMW_WR: begin
            pmem_write = 1'b1;
            if (pmem_resp) next_state = DONE;
         end
         DONE: begin
            resp_a     = !port_b_q;
            resp_b     = port_b_q;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Request latch at grant, line capture/merge on memory completion, read data registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         mbe_q    <= '0;
         line_q   <= '0;
         port_b_q <= 1'b0;
         rdata_a  <= '0;
         rdata_b  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (write) begin
                  addr_q   <= address_b;
                  wdata_q  <= wdata;
                  mbe_q    <= mbe;
                  port_b_q <= 1'b1;
               end else if (read_b) begin
                  addr_q   <= address_b;
                  port_b_q <= 1'b1;
               end else if (read_a) begin
                  addr_q   <= address_a;
                  port_b_q <= 1'b0;
                  if (buf_hit) rdata_a <= sel_word;
               end
            end
            RD_A: if (pmem_resp) begin
               line_q  <= pmem_rdata;
               rdata_a <= sel_word;
            end
            RD_B: if (pmem_resp) begin
               line_q  <= pmem_rdata;
               rdata_b <= sel_word;
            end
            RMW_RD: if (pmem_resp) line_q <= merged_line;
            default: ;
         endcase
      end
   end

   // read_b together with write is illegal; the write is serviced.
   a_no_rd_wr_pair: assert property (@(posedge clk) disable iff (!rst_n)
      (state == IDLE) |-> !(read_b && write))
      else $warning("read_b and write asserted together; servicing the write");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a shadow-memory reference model,
// a latency-programmable line-memory responder and a per-cycle compare process.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int LAT = 3;
`ifdef MEM_PORT_ARBITER_LINE_BUF_EN
   localparam bit BUF_EN = 1'b1;
`else
   localparam bit BUF_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         read_a = 1'b0, read_b = 1'b0, write = 1'b0;
   logic [31:0]  address_a = '0, address_b = '0, wdata = '0;
   logic [3:0]   mbe = '0;
   logic         resp_a, resp_b, pmem_read, pmem_write;
   logic [31:0]  rdata_a, rdata_b, pmem_address;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata = '0;
   logic         pmem_resp = 1'b0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.LINE_W(256), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
      .read_b(read_b), .write(write), .address_b(address_b), .wdata(wdata), .mbe(mbe),
      .resp_b(resp_b), .rdata_b(rdata_b),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   int tests = 0;
   int fails = 0;

   logic [255:0] phys [64];   // memory seen by the DUT
   logic [255:0] refm [64];   // reference model memory
   int n_rd = 0, n_wr = 0;

   bit          exp_port [$];  // 1 = port b
   bit          exp_isrd [$];
   logic [31:0] exp_data [$];
   logic [31:0] last_a = '0, last_b = '0;
   logic [31:0] cur_line = '0;
   bit          bufm_v = 1'b0;
   logic [26:0] bufm_tag = '0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [255:0] l, input logic [31:0] a);
      return l[a[4:2]*32 +: 32];
   endfunction

   // Line memory responder: answers each held request after LAT cycles.
   initial begin
      int cnt;
      logic [5:0] idx;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            cnt = 0;
            pmem_resp = 1'b0;
         end else if (pmem_resp) begin
            pmem_resp = 1'b0;
            cnt = 0;
         end else if (pmem_read || pmem_write) begin
            cnt++;
            if (cnt == LAT) begin
               idx = pmem_address[10:5];
               if (pmem_write) begin
                  phys[idx] = pmem_wdata;
                  n_wr++;
               end else begin
                  pmem_rdata = phys[idx];
                  n_rd++;
               end
               pmem_resp = 1'b1;
               cnt = 0;
            end
         end
      end
   end

   // Per-cycle compare against the model.
   initial begin
      bit prev_wait;
      logic prev_rd, prev_wr;
      logic [31:0] prev_addr;
      bit ep, ei;
      logic [31:0] ed;
      prev_wait = 1'b0;
      prev_rd = 1'b0; prev_wr = 1'b0; prev_addr = '0;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            last_a = '0;
            last_b = '0;
            prev_wait = 1'b0;
         end else begin
            chk("pmem_rd_wr_exclusive", pmem_read & pmem_write, 0);
            if (pmem_read || pmem_write) chk("pmem_address", pmem_address, cur_line);
            if (prev_wait && !pmem_resp)
               chk("pmem_hold", {pmem_read, pmem_write, pmem_address}, {prev_rd, prev_wr, prev_addr});
            prev_wait = (pmem_read || pmem_write) && !pmem_resp;
            prev_rd = pmem_read; prev_wr = pmem_write; prev_addr = pmem_address;
            if (resp_a || resp_b) begin
               if (exp_port.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL resp_unexpected: resp_a=%0b resp_b=%0b required none", resp_a, resp_b);
               end else begin
                  ep = exp_port.pop_front();
                  ei = exp_isrd.pop_front();
                  ed = exp_data.pop_front();
                  chk("resp_port", {resp_a, resp_b}, ep ? 2'b01 : 2'b10);
                  if (ei) begin
                     if (ep) last_b = ed;
                     else    last_a = ed;
                  end
               end
            end
            chk("rdata_a", rdata_a, last_a);
            chk("rdata_b", rdata_b, last_b);
         end
      end
   end

   // One request through the model and the DUT, with latency and traffic checks.
   task automatic run_req(input string name, input bit ra, input bit rb, input bit wr,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
      int lat, rd0, wr0, exp_rd, exp_wr, exp_lat;
      bit done, hit, pb;
      logic [5:0] idx;
      idx = addr[10:5];
      pb  = wr || rb;
      hit = BUF_EN && !pb && bufm_v && (bufm_tag == addr[31:5]);
      if (wr) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) refm[idx][addr[4:2]*32 + i*8 +: 8] = wd[i*8 +: 8];
         exp_rd = 1; exp_wr = 1; exp_lat = 2*LAT + 2;
         exp_port.push_back(1'b1); exp_isrd.push_back(1'b0); exp_data.push_back('0);
      end else begin
         exp_rd = hit ? 0 : 1; exp_wr = 0; exp_lat = LAT + 1;
         exp_port.push_back(pb); exp_isrd.push_back(1'b1);
         exp_data.push_back(word_of(refm[idx], addr));
      end
      if (!pb) begin
         bufm_v = 1'b1;
         bufm_tag = addr[31:5];
      end
      cur_line = {addr[31:5], 5'b0};
      @(negedge clk);
      rd0 = n_rd; wr0 = n_wr;
      read_a = ra; read_b = rb; write = wr;
      address_a = ra ? addr : '0;
      address_b = pb ? addr : '0;
      wdata = wd; mbe = be;
      lat = 0; done = 1'b0;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
         if (pb ? resp_b : resp_a) done = 1'b1;
         else begin
            address_a = 32'hFFFF_FFE0; address_b = 32'hFFFF_FFE0;
            wdata = ~wd; mbe = ~be;
         end
      end
      read_a = 1'b0; read_b = 1'b0; write = 1'b0;
      chk({name, "_resp"}, done, 1);
      if (hit) chk({name, "_hit_lat"}, lat <= 2, 1);
      else     chk({name, "_lat"}, lat, exp_lat);
      chk({name, "_pmem_reads"}, n_rd - rd0, exp_rd);
      chk({name, "_pmem_writes"}, n_wr - wr0, exp_wr);
   endtask

   initial begin
      int k, rd0, wr0;
      logic [255:0] snap;
      bit got;
      for (int i = 0; i < 64; i++)
         for (int w = 0; w < 8; w++)
            phys[i][32*w +: 32] = 32'hA500_0000 | (i << 8) | w;
      phys[3][95:64] = 32'hDEAD_BEEF;
      phys[8][63:32] = 32'h1122_3344;
      for (int i = 0; i < 64; i++) refm[i] = phys[i];

      // Reset state
      #1 rst_n = 1'b0;
      #2;
      chk("rst_resp", {resp_a, resp_b}, 0);
      chk("rst_pmem_req", {pmem_read, pmem_write}, 0);
      chk("rst_pmem_address", pmem_address, 0);
      chk("rst_pmem_wdata", pmem_wdata, 0);
      chk("rst_rdata", {rdata_a, rdata_b}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Port a read
      run_req("read_a_68", 1, 0, 0, 32'h68, '0, '0);
      chk("read_a_68_data", rdata_a, 32'hDEAD_BEEF);

      // Partial write then read-back
      run_req("wr_104", 0, 0, 1, 32'h104, 32'hAABB_CCDD, 4'b0101);
      chk("wr_104_word1", phys[8][63:32], 32'h11BB_33DD);
      chk("wr_104_model", refm[8][63:32], 32'h11BB_33DD);
      chk("wr_104_word0", phys[8][31:0], 32'hA500_0800);
      run_req("rd_b_104", 0, 1, 0, 32'h104, '0, '0);
      chk("rd_b_104_data", rdata_b, 32'h11BB_33DD);

      // Simultaneous a and b: b first
      exp_port.push_back(1'b1); exp_isrd.push_back(1'b1); exp_data.push_back(word_of(refm[2], 32'h40));
      exp_port.push_back(1'b0); exp_isrd.push_back(1'b1); exp_data.push_back(word_of(refm[0], 32'h0));
      bufm_v = 1'b1; bufm_tag = '0;
      cur_line = 32'h40;
      @(negedge clk);
      rd0 = n_rd; wr0 = n_wr;
      read_a = 1'b1; address_a = 32'h0; read_b = 1'b1; address_b = 32'h40;
      k = 0;
      while (!resp_b && k < 50) begin @(negedge clk); k++; end
      chk("sim_b_resp", resp_b, 1);
      chk("sim_a_waits", resp_a, 0);
      read_b = 1'b0; cur_line = 32'h0;
      k = 0;
      while (!resp_a && k < 50) begin @(negedge clk); k++; end
      chk("sim_a_resp", resp_a, 1);
      read_a = 1'b0;
      chk("sim_pmem_reads", n_rd - rd0, 2);
      chk("sim_pmem_writes", n_wr - wr0, 0);
      chk("sim_b_data", rdata_b, 32'hA500_0200);

      // Empty byte mask still writes the line back
      snap = phys[12];
      run_req("wr_mbe0", 0, 0, 1, 32'h188, 32'h5555_5555, 4'b0000);
      chk("wr_mbe0_line", phys[12], snap);

      // Illegal read_b + write: handled as the write
      run_req("illegal", 0, 1, 1, 32'h1C0, 32'h0102_0304, 4'b1000);
      chk("illegal_word0", phys[14][31:0], 32'h0100_0E00);

      // Port-a line reuse, then write into that line and read it back
      run_req("buf_200", 1, 0, 0, 32'h200, '0, '0);
      chk("buf_200_data", rdata_a, 32'hA500_1000);
      run_req("buf_204", 1, 0, 0, 32'h204, '0, '0);
      chk("buf_204_data", rdata_a, 32'hA500_1001);
      run_req("buf_wr_204", 0, 0, 1, 32'h204, 32'hCAFE_F00D, 4'b1111);
      run_req("buf_rd_204", 1, 0, 0, 32'h204, '0, '0);
      chk("buf_rd_204_data", rdata_a, 32'hCAFE_F00D);

      // Asynchronous reset during RMW_RD
      snap = phys[10];
      cur_line = 32'h140;
      @(negedge clk);
      write = 1'b1; address_b = 32'h144; wdata = 32'h1234_5678; mbe = 4'hF;
      k = 0;
      while (!pmem_read && k < 20) begin @(negedge clk); k++; end
      chk("arst_in_rmw_rd", pmem_read, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_pmem_read_drop", pmem_read, 0);
      chk("arst_pmem_write", pmem_write, 0);
      chk("arst_resp_b", resp_b, 0);
      write = 1'b0; address_b = '0; wdata = '0; mbe = '0;
      bufm_v = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rd0 = n_rd; wr0 = n_wr; got = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (resp_b) got = 1'b1;
      end
      chk("arst_no_resp", got, 0);
      chk("arst_no_pmem", (n_rd - rd0) + (n_wr - wr0), 0);
      chk("arst_line_kept", phys[10], snap);
      chk("arst_rdata_a_clr", rdata_a, 0);

      // Post-reset read of line 0x60 again
      run_req("read_a_after_rst", 1, 0, 0, 32'h68, '0, '0);
      chk("read_a_after_rst_data", rdata_a, 32'hDEAD_BEEF);

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", exp_port.size(), 0);
      for (int i = 0; i < 64; i++) chk("final_memory", phys[i], refm[i]);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Synthesizable bridge between the CPU's two 32-bit memory ports and a single 256-bit line-granular physical memory port.
  - Port a: instruction read only.
  - Port b: data read, or data write with byte enables.
- Serialises both ports onto one memory, performs read-modify-write for partial-line writes, and returns single-cycle responses.
- Its port-side outputs (resp_a/rdata_a, resp_b/rdata_b) are exactly what the testbench shadow-memory checker samples.

Parameters:
- LINE_W, 256, physical memory line width in bits; fixed at 256 (32-byte lines, addr[4:2] selects the word).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- read_a  in  1  instruction read request, held until resp_a
- address_a  in  32  instruction byte address, word aligned
- resp_a  out  1  one-cycle pulse, rdata_a valid
- rdata_a  out  32  instruction word
- read_b  in  1  data read request, held until resp_b
- write  in  1  data write request, held until resp_b
- address_b  in  32  data byte address, word aligned
- wdata  in  32  write data
- mbe  in  4  byte enables; bit i covers wdata[8i+:8]
- resp_b  out  1  one-cycle pulse completing a read_b or write
- rdata_b  out  32  data read word
- pmem_read  out  1  line read request, held until pmem_resp
- pmem_write  out  1  line write request, held until pmem_resp
- pmem_address  out  32  line address {addr[31:5], 5'b0}
- pmem_wdata  out  256  line write data
- pmem_rdata  in  256  line read data, valid with pmem_resp
- pmem_resp  in  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_n low):
  - All outputs 0; FSM goes to IDLE; latched address/data cleared.
  - Any in-flight pmem transaction is abandoned and pmem_read/pmem_write drop immediately.
  - No response is issued for a request that was pending when reset asserted.
- FSM states: IDLE, RD_A, RD_B, RMW_RD, RMW_WR, DONE.
- IDLE arbitration, fixed priority:
  - write -> RMW_RD.
  - else read_b -> RD_B.
  - else read_a -> RD_A.
  - At the grant edge, the granted port's address (plus wdata/mbe for a write) is latched. Later changes on the inputs are ignored until the response.
- RD_A / RD_B / RMW_RD:
  - pmem_read=1, pmem_address = latched line address.
  - On pmem_resp, the line is captured into the line register.
- RD_A / RD_B exit: -> DONE, with the selected word, line[32*addr[4:2] +: 32], registered onto rdata_a or rdata_b.
- RMW_RD exit: merge wdata into line word addr[4:2] per mbe -> RMW_WR.
  - mbe=4'b0000 still performs a full write-back of the unchanged line.
- RMW_WR: pmem_write=1 with the merged line on pmem_wdata; on pmem_resp -> DONE.
- DONE:
  - Exactly one of resp_a/resp_b is high for one cycle.
  - rdata_b is unchanged for writes.
  - Unconditionally -> IDLE; the requester drops its request in this cycle.
  - A request still high in IDLE is treated as new.
- pmem_read and pmem_write are never high together. Both stay stable while waiting for pmem_resp.
- Latency: grant edge -> pmem request on the next cycle.
  - Read: resp one cycle after pmem_resp.
  - Write: two memory transactions, then resp.
- read_b and write both high is illegal. Write wins, and a simulation-only assertion fires.
- rdata_a/rdata_b hold their last value between responses.

Optional Feature:
- Macro: MEM_PORT_ARBITER_LINE_BUF_EN.
- Defined:
  - One-entry port-a line buffer (valid bit, tag addr[31:5], 256-bit line), filled on every RD_A completion.
  - read_a in IDLE hitting the tag (no higher-priority request) -> DONE directly; resp_a follows two cycles after request, with no pmem traffic.
  - Any write (RMW_WR completion) to the buffered line updates the buffer with the merged line.
  - Reset clears the valid bit.
- Undefined: every port-a read goes to pmem; no buffer storage is synthesized.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum arb_state_t.
  - localparams LINE_BYTES=32 and OFFSET_W=5.
  - Function line_addr(addr).
  - Function merge_word(line, off, wdata, mbe).
- One natural sub-module: line_merge, a combinational word select plus byte-enable merge, reused for the rdata extract and the RMW path.

Test Plan:
- Read a: preload line 0x60 with word2=0xDEADBEEF; read_a, address_a=0x68 -> one pmem_read at 0x60, then resp_a with rdata_a=0xDEADBEEF.
- Partial write: line 0x100 word1=0x11223344; write, address_b=0x104, wdata=0xAABBCCDD, mbe=4'b0101 -> pmem_read then pmem_write at 0x100 with word1=0x11BB33DD, other words unchanged; one resp_b.
- Simultaneous: read_a@0x0 and read_b@0x40 asserted in the same cycle -> port b served first (resp_b), then port a (resp_a); no overlap between pmem_read and pmem_write.
- Async reset: drop rst_n while in RMW_RD with pmem_read=1 -> pmem_read goes 0 without waiting for a clock edge; no resp_b after release; memory line unchanged.
- Illegal and empty requests: read_b=write=1 -> treated as a write, assertion fires; mbe=0 -> line written back unchanged, resp_b issued.
- With MEM_PORT_ARBITER_LINE_BUF_EN: read_a 0x200 then 0x204 -> single pmem_read, second resp_a after two cycles. Then write 0x204 and read_a 0x204 -> returns the new data.
